// File: rtl/zion_basic_circuit_lib_pkg.sv
// Shared types for the zion basic circuit library.
// The skid state encoding doubles as the held-entry count.
package zion_basic_circuit_lib_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/zion_basic_circuit_lib_skid_buf_if.sv
// Valid/ready handshake bundle for the skid buffer: upstream side (i*Valid/iDat/oReady)
// and downstream side (oValid/oDat/iReady), named from the buffer's point of view.
interface zion_basic_circuit_lib_skid_buf_if #(
  parameter int unsigned WIDTH = 8
);
  logic             iValid;
  logic             oReady;
  logic [WIDTH-1:0] iDat;
  logic             oValid;
  logic             iReady;
  logic [WIDTH-1:0] oDat;

  // Environment side: produces upstream data and downstream ready.
  modport master (
    output iValid, iDat, iReady,
    input  oReady, oValid, oDat
  );

  // Buffer side.
  modport slave (
    input  iValid, iDat, iReady,
    output oReady, oValid, oDat
  );
endinterface

// File: rtl/zion_basic_circuit_lib_sync_clr_en_dff.sv
// Data register with synchronous active-high reset, clear and enable.
// Reset and clear both load INI_DATA; clear wins over enable.
module zion_basic_circuit_lib_sync_clr_en_dff #(
  parameter int unsigned      WIDTH    = 8,
  parameter logic [WIDTH-1:0] INI_DATA = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iClr,
  input  logic             iEn,
  input  logic [WIDTH-1:0] iDat,
  output logic [WIDTH-1:0] oDat
);

  logic [WIDTH-1:0] r_dat;

  always_ff @(posedge clk) begin
    if (rst || iClr) begin
      r_dat <= INI_DATA;
    end else if (iEn) begin
      r_dat <= iDat;
    end
  end

  assign oDat = r_dat;

endmodule

// File: rtl/zion_basic_circuit_lib_skid_buf.sv
// Two-entry valid/ready skid buffer. oReady comes from a flop (gated only by iFlush),
// so the upstream ready path is registered while still sustaining one transfer per cycle.
module zion_basic_circuit_lib_skid_buf
  import zion_basic_circuit_lib_pkg::*;
#(
  parameter int unsigned      WIDTH    = 8,
  parameter logic [WIDTH-1:0] INI_DATA = '0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               iFlush,
  zion_basic_circuit_lib_skid_buf_if.slave   bus,
  output logic [1:0]                         oCnt
);

  skid_state_e      r_state;
  skid_state_e      w_state_nxt;
  logic             r_ready;
  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_main_en;
  logic             w_skid_en;
  logic [WIDTH-1:0] w_main_din;
  logic [WIDTH-1:0] w_skid_dat;

  assign bus.oReady = r_ready & ~iFlush;
  assign bus.oValid = (r_state != EMPTY);
  assign oCnt       = r_state;
  assign w_in_fire  = bus.iValid & bus.oReady;
  assign w_out_fire = bus.oValid & bus.iReady;

  always_comb begin
    w_state_nxt = r_state;
    w_main_en   = 1'b0;
    w_skid_en   = 1'b0;
    unique case (r_state)
      EMPTY: begin
        if (w_in_fire) begin
          w_main_en   = 1'b1;
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (w_in_fire && w_out_fire) begin
          w_main_en = 1'b1;
        end else if (w_in_fire) begin
          w_skid_en   = 1'b1;
          w_state_nxt = FULL;
        end else if (w_out_fire) begin
          w_state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (w_out_fire) begin
          w_main_en   = 1'b1;
          w_state_nxt = BUSY;
        end
      end
      default: w_state_nxt = EMPTY;
    endcase
    if (iFlush) begin
      w_state_nxt = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= EMPTY;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= (w_state_nxt != FULL);
    end
  end

  // When draining from FULL the main register reloads from the skid entry.
  assign w_main_din = (r_state == FULL) ? w_skid_dat : bus.iDat;

  zion_basic_circuit_lib_sync_clr_en_dff #(
    .WIDTH    (WIDTH),
    .INI_DATA (INI_DATA)
  ) u_main (
    .clk  (clk),
    .rst  (rst),
    .iClr (iFlush),
    .iEn  (w_main_en),
    .iDat (w_main_din),
    .oDat (bus.oDat)
  );

  zion_basic_circuit_lib_sync_clr_en_dff #(
    .WIDTH    (WIDTH),
    .INI_DATA (INI_DATA)
  ) u_skid (
    .clk  (clk),
    .rst  (rst),
    .iClr (iFlush),
    .iEn  (w_skid_en),
    .iDat (bus.iDat),
    .oDat (w_skid_dat)
  );

  a_cnt_matches_state: assert property (@(posedge clk) oCnt == r_state);

  a_no_in_fire_full: assert property (@(posedge clk) disable iff (rst)
    !((r_state == FULL) && w_in_fire));

  a_valid_held: assert property (@(posedge clk) disable iff (rst)
    (bus.oValid && !bus.iReady && !iFlush) |=> bus.oValid);

endmodule

// File: tb/tb_zion_basic_circuit_lib_skid_buf.sv
// Bench for the skid buffer: a reference queue model checked against every output on
// each falling edge while directed and random stimulus is driven after the rising edge.
module tb_zion_basic_circuit_lib_skid_buf;

  localparam int unsigned      WIDTH = 8;
  localparam logic [WIDTH-1:0] INI   = 8'hA5;

  logic       clk;
  logic       rst;
  logic       flush;
  logic [1:0] cnt;

  zion_basic_circuit_lib_skid_buf_if #(.WIDTH(WIDTH)) bus ();

  zion_basic_circuit_lib_skid_buf #(
    .WIDTH    (WIDTH),
    .INI_DATA (INI)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .iFlush (flush),
    .bus    (bus),
    .oCnt   (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  bit          chk_en   = 1'b0;

  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] m_stale = INI;
  logic             m_ready = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: compares current outputs, then advances to the state after the next edge.
  always @(negedge clk) begin
    if (chk_en) begin
      logic             exp_valid;
      logic             exp_rdy;
      logic [WIDTH-1:0] exp_dat;
      logic             accept;
      logic             deliver;
      exp_valid = (exp_q.size() != 0);
      exp_rdy   = m_ready && !flush;
      exp_dat   = exp_valid ? exp_q[0] : m_stale;
      check_eq("oValid", bus.oValid, exp_valid);
      check_eq("oReady", bus.oReady, exp_rdy);
      check_eq("oCnt",   cnt, exp_q.size());
      check_eq("oDat",   bus.oDat, exp_dat);
      accept  = bus.iValid && exp_rdy;
      deliver = exp_valid && bus.iReady;
      if (rst) begin
        exp_q.delete();
        m_stale = INI;
        m_ready = 1'b0;
      end else if (flush) begin
        exp_q.delete();
        m_stale = INI;
        m_ready = 1'b1;
      end else begin
        if (deliver) m_stale = exp_q.pop_front();
        if (accept)  exp_q.push_back(bus.iDat);
        m_ready = (exp_q.size() != 2);
      end
    end
  end

  task automatic cyc(input logic r, input logic f, input logic v, input logic [WIDTH-1:0] d,
                     input logic rdy);
    rst        = r;
    flush      = f;
    bus.iValid = v;
    bus.iDat   = d;
    bus.iReady = rdy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst        = 1'b1;
    flush      = 1'b0;
    bus.iValid = 1'b0;
    bus.iDat   = '0;
    bus.iReady = 1'b0;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    cyc(1, 0, 0, 8'h00, 0);
    // Reset release: one dead ready cycle, then ready.
    cyc(0, 0, 0, 8'h00, 0);
    cyc(0, 0, 0, 8'h00, 0);
    // Streaming.
    for (int i = 1; i <= 4; i++) cyc(0, 0, 1, 8'(i), 1);
    cyc(0, 0, 0, 8'h00, 1);
    cyc(0, 0, 0, 8'h00, 1);
    // Backpressure then drain.
    cyc(0, 0, 1, 8'h10, 0);
    cyc(0, 0, 1, 8'h11, 0);
    cyc(0, 0, 1, 8'h12, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 8'h00, 1);
    // Flush while FULL with a competing input.
    cyc(0, 0, 1, 8'h20, 0);
    cyc(0, 0, 1, 8'h21, 0);
    cyc(0, 1, 1, 8'h22, 0);
    cyc(0, 0, 0, 8'h00, 0);
    cyc(0, 0, 0, 8'h00, 1);
    // Simultaneous in/out while BUSY.
    cyc(0, 0, 1, 8'h30, 0);
    cyc(0, 0, 1, 8'h31, 1);
    cyc(0, 0, 0, 8'h00, 0);
    cyc(0, 0, 0, 8'h00, 1);
    // Reset beats flush while FULL.
    cyc(0, 0, 1, 8'h40, 0);
    cyc(0, 0, 1, 8'h41, 0);
    cyc(1, 1, 1, 8'h42, 1);
    cyc(0, 0, 1, 8'h43, 0);
    cyc(0, 0, 1, 8'h44, 0);
    cyc(0, 0, 0, 8'h00, 1);
    cyc(0, 0, 0, 8'h00, 1);
    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(63) == 0), ($urandom_range(31) == 0), $urandom_range(1),
          8'($urandom), ($urandom_range(3) != 0));
    end
    cyc(0, 0, 0, 8'h00, 1);
    cyc(0, 0, 0, 8'h00, 1);
    cyc(0, 0, 0, 8'h00, 1);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
